// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one main-memory port between the instruction cache and the data
// cache. The instruction cache only refills lines. The data cache refills
// lines or writes back dirty lines. One owner is granted at a time, and the
// arbiter runs a LINE_WORDS-beat burst with a per-beat req/ack handshake.
// Read beats go back to the owner with a one-cycle rvalid. The owner also
// gets a one-cycle done pulse that coincides with the last read beat.
//
// Sequence: IDLE -> BURST -> DONE -> IDLE. A new grant is only possible
// from IDLE, so there is at least one idle cycle between bursts.
//
// Optional feature (compile-time macro MEM_ARB_ROUND_ROBIN_EN):
//   defined   : simultaneous requests are granted to the requester that was
//               not granted last. After reset the last grant counts as the
//               icache, so the dcache wins the first tie.
//   undefined : fixed priority. The dcache always wins ties.
//
// Ports
//   clk_i, rst_i                    clock, synchronous active-low reset
//   i_req_i / i_addr_i              icache refill request and miss address
//   i_rdata_o / i_rvalid_o          icache refill beat and its valid strobe
//   i_done_o                        icache burst complete pulse
//   d_req_i / d_we_i / d_addr_i     dcache request, write-back flag, address
//   d_wdata_i                       write-back word for beat d_beat_o
//   d_beat_o                        current dcache beat (0 when not owner)
//   d_rdata_o / d_rvalid_o          dcache refill beat and its valid strobe
//   d_done_o                        dcache burst complete pulse
//   mem_req_o .. mem_ack_i          per-beat memory handshake
//   owner_o                         00 none, 01 icache, 10 dcache
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          i_req_i,
  input  logic [ADDR_W-1:0]             i_addr_i,
  output logic [DATA_W-1:0]             i_rdata_o,
  output logic                          i_rvalid_o,
  output logic                          i_done_o,
  input  logic                          d_req_i,
  input  logic                          d_we_i,
  input  logic [ADDR_W-1:0]             d_addr_i,
  input  logic [DATA_W-1:0]             d_wdata_i,
  output logic [$clog2(LINE_WORDS)-1:0] d_beat_o,
  output logic [DATA_W-1:0]             d_rdata_o,
  output logic                          d_rvalid_o,
  output logic                          d_done_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  input  logic [DATA_W-1:0]             mem_rdata_i,
  input  logic                          mem_ack_i,
  output logic [1:0]                    owner_o
);

  localparam int BEAT_W = $clog2(LINE_WORDS);
  // Byte offset of a line: word index bits plus the 2 byte-in-word bits.
  localparam int OFF_W  = BEAT_W + 2;

  localparam logic [1:0]        OWN_NONE  = 2'b00;
  localparam logic [1:0]        OWN_I     = 2'b01;
  localparam logic [1:0]        OWN_D     = 2'b10;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [1:0]          r_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_base;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_mem_req;
  logic [DATA_W-1:0]   r_i_rdata;
  logic                r_i_rvalid;
  logic                r_i_done;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_d_rvalid;
  logic                r_d_done;

  logic                w_any_req;
  logic                w_grant_d;
  logic                w_unused_addr;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Set when the most recent grant went to the dcache.
  logic                r_last_d;
`endif

  // The byte offset within a line is never used, because bursts always
  // start at the line base.
  assign w_unused_addr = ^{i_addr_i[OFF_W-1:0], d_addr_i[OFF_W-1:0]};

  assign w_any_req = i_req_i | d_req_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign w_grant_d = d_req_i & (~i_req_i | ~r_last_d);
`else
  assign w_grant_d = d_req_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_owner    <= OWN_NONE;
      r_we       <= 1'b0;
      r_base     <= '0;
      r_beat     <= '0;
      r_mem_req  <= 1'b0;
      r_i_rdata  <= '0;
      r_i_rvalid <= 1'b0;
      r_i_done   <= 1'b0;
      r_d_rdata  <= '0;
      r_d_rvalid <= 1'b0;
      r_d_done   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_last_d   <= 1'b0;
`endif
    end else begin
      // rvalid and done are single-cycle strobes.
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_done   <= 1'b0;
      r_d_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state   <= S_BURST;
            r_mem_req <= 1'b1;
            r_beat    <= '0;
            if (w_grant_d) begin
              r_owner <= OWN_D;
              r_we    <= d_we_i;
              r_base  <= {d_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end else begin
              r_owner <= OWN_I;
              r_we    <= 1'b0;
              r_base  <= {i_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_d <= w_grant_d;
`endif
          end
        end
        S_BURST: begin
          if (mem_ack_i) begin
            if (!r_we) begin
              if (r_owner == OWN_D) begin
                r_d_rdata  <= mem_rdata_i;
                r_d_rvalid <= 1'b1;
              end else begin
                r_i_rdata  <= mem_rdata_i;
                r_i_rvalid <= 1'b1;
              end
            end
            if (r_beat == LAST_BEAT) begin
              // The beat wraps to 0 only here, so the address never leaves
              // the line. The done pulse lands on the same cycle as the
              // last rvalid.
              r_beat    <= '0;
              r_state   <= S_DONE;
              r_mem_req <= 1'b0;
              r_d_done  <= (r_owner == OWN_D);
              r_i_done  <= (r_owner == OWN_I);
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_owner <= OWN_NONE;
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_owner   <= OWN_NONE;
          r_mem_req <= 1'b0;
          r_beat    <= '0;
        end
      endcase
    end
  end

  // The memory-side address, write enable and write data are forced to
  // zero whenever no beat is being requested.
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_req & r_we;
  assign mem_addr_o  = r_mem_req ? (r_base + ADDR_W'({r_beat, 2'b00})) : '0;
  assign mem_wdata_o = (r_mem_req & r_we) ? d_wdata_i : '0;

  assign d_beat_o    = (r_owner == OWN_D) ? r_beat : '0;
  assign owner_o     = r_owner;

  assign i_rdata_o   = r_i_rdata;
  assign i_rvalid_o  = r_i_rvalid;
  assign i_done_o    = r_i_done;
  assign d_rdata_o   = r_d_rdata;
  assign d_rvalid_o  = r_d_rvalid;
  assign d_done_o    = r_d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int LW     = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        i_req_i = 1'b0;
  logic [31:0] i_addr_i = '0;
  logic [31:0] i_rdata_o;
  logic        i_rvalid_o, i_done_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [31:0] d_addr_i = '0;
  logic [31:0] d_wdata_i;
  logic [1:0]  d_beat_o;
  logic [31:0] d_rdata_o;
  logic        d_rvalid_o, d_done_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;
  logic [1:0]  owner_o;

  mem_port_arbiter #(.LINE_WORDS(LW), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o),
    .i_rvalid_o(i_rvalid_o), .i_done_o(i_done_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_beat_o(d_beat_o), .d_rdata_o(d_rdata_o), .d_rvalid_o(d_rvalid_o), .d_done_o(d_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .owner_o(owner_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Environment: the dcache write-back source and the memory behaviour
  logic [31:0] wd_base = 32'hD0;
  logic [31:0] rd_base = 32'hA0;
  bit          dir_rd  = 1'b1;
  int          ack_mode = 0;     // 0 every cycle, 1 every 2nd cycle, 2 random
  bit          ack_tgl = 1'b0;

  assign d_wdata_i = wd_base + 32'(d_beat_o);

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (dir_rd) return rd_base + 32'(a[3:2]);
    return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  always @(negedge clk_i) begin
    if (mem_req_o) begin
      case (ack_mode)
        0:       mem_ack_i = 1'b1;
        1:       begin mem_ack_i = ack_tgl; ack_tgl = ~ack_tgl; end
        default: mem_ack_i = ($urandom_range(0, 2) != 0);
      endcase
      mem_rdata_i = mem_ack_i ? mem_fn(mem_addr_o) : $urandom;
    end else begin
      mem_ack_i   = 1'b0;
      mem_rdata_i = $urandom;
    end
  end

  // Transaction-level reference: who owns the port, how many beats are acked
  int          m_owner = 0;   // 0 none, 1 icache, 2 dcache
  int          m_k = 0;       // beats acknowledged so far (LW = done cycle)
  bit          m_we = 0, m_last_d = 0, m_rv_i = 0, m_rv_d = 0;
  logic [31:0] m_base = '0, m_rdata_i = '0, m_rdata_d = '0;
  bit          mon_en = 0;

  always @(posedge clk_i) begin
    bit g_d;
    logic [31:0] a;
    if (!rst_i) begin
      m_owner = 0; m_k = 0; m_we = 0; m_last_d = 0; m_rv_i = 0; m_rv_d = 0;
    end else begin
      m_rv_i = 0; m_rv_d = 0;
      if (m_owner == 0) begin
        if (i_req_i || d_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          g_d = d_req_i && (!i_req_i || !m_last_d);
`else
          g_d = d_req_i;
`endif
          m_owner  = g_d ? 2 : 1;
          m_we     = g_d ? d_we_i : 1'b0;
          a        = g_d ? d_addr_i : i_addr_i;
          m_base   = a & ~32'(LW * 4 - 1);
          m_k      = 0;
          m_last_d = g_d;
        end
      end else if (m_k == LW) begin
        m_owner = 0; m_k = 0;
      end else if (mem_ack_i) begin
        if (!m_we) begin
          if (m_owner == 2) begin m_rv_d = 1; m_rdata_d = mem_fn(m_base + 32'(4 * m_k)); end
          else              begin m_rv_i = 1; m_rdata_i = mem_fn(m_base + 32'(4 * m_k)); end
        end
        m_k++;
      end
    end
  end

  always @(negedge clk_i) begin
    bit e_req;
    if (mon_en) begin
      e_req = (m_owner != 0) && (m_k < LW);
      chk("owner_o", 32'(owner_o), 32'(m_owner));
      chk("mem_req_o", 32'(mem_req_o), 32'(e_req));
      chk("mem_we_o", 32'(mem_we_o), 32'(e_req && m_we));
      chk("mem_addr_o", mem_addr_o, e_req ? m_base + 32'(4 * m_k) : 32'h0);
      chk("mem_wdata_o", mem_wdata_o, (e_req && m_we) ? wd_base + 32'(m_k) : 32'h0);
      chk("d_beat_o", 32'(d_beat_o), (m_owner == 2 && m_k < LW) ? 32'(m_k) : 32'h0);
      chk("i_rvalid_o", 32'(i_rvalid_o), 32'(m_rv_i));
      chk("d_rvalid_o", 32'(d_rvalid_o), 32'(m_rv_d));
      if (m_rv_i) chk("i_rdata_o", i_rdata_o, m_rdata_i);
      if (m_rv_d) chk("d_rdata_o", d_rdata_o, m_rdata_d);
      chk("i_done_o", 32'(i_done_o), 32'(m_owner == 1 && m_k == LW));
      chk("d_done_o", 32'(d_done_o), 32'(m_owner == 2 && m_k == LW));
    end
  end

  // Directed helpers (run at negedge + 1 so the memory has settled)
  task automatic cyc();
    @(negedge clk_i);
    #1;
  endtask

  int          nrv, nacc, other, last_rv_done;
  logic [31:0] rv [8];
  logic [31:0] acc_addr [8];
  logic [31:0] acc_wd [8];
  logic        acc_we [8];

  task automatic run_burst(input bit is_d, input int maxc, output bit ok);
    nrv = 0; nacc = 0; other = 0; ok = 0; last_rv_done = 0;
    for (int c = 0; c < maxc && !ok; c++) begin
      cyc();
      if (mem_req_o && mem_ack_i && owner_o == (is_d ? 2'b10 : 2'b01) && nacc < 8) begin
        acc_addr[nacc] = mem_addr_o; acc_wd[nacc] = mem_wdata_o; acc_we[nacc] = mem_we_o;
        nacc++;
      end
      if (is_d) begin
        if (d_rvalid_o && nrv < 8) begin rv[nrv] = d_rdata_o; nrv++; end
        other += int'(i_rvalid_o) + int'(i_done_o);
        if (d_done_o) begin ok = 1; last_rv_done = d_rvalid_o; d_req_i = 0; end
      end else begin
        if (i_rvalid_o && nrv < 8) begin rv[nrv] = i_rdata_o; nrv++; end
        other += int'(d_rvalid_o) + int'(d_done_o);
        if (i_done_o) begin ok = 1; last_rv_done = i_rvalid_o; i_req_i = 0; end
      end
    end
    chk(is_d ? "d_burst_timeout" : "i_burst_timeout", 32'(ok), 32'h1);
  endtask

  int n_bursts = 0;

  initial begin
    bit ok;
    // Reset: 2 cycles low
    rst_i = 0;
    cyc(); cyc();
    chk("rst_owner", 32'(owner_o), 32'h0);
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    chk("rst_strobes", 32'({i_done_o, d_done_o, i_rvalid_o, d_rvalid_o}), 32'h0);
    rst_i = 1;
    mon_en = 1;

    // icache refill at 0x104, ack every cycle
    ack_mode = 0; dir_rd = 1; rd_base = 32'hA0;
    i_addr_i = 32'h104; i_req_i = 1;
    run_burst(0, 30, ok);
    for (int j = 0; j < 4; j++) begin
      chk("i_addr_seq", acc_addr[j], 32'h100 + 32'(4 * j));
      chk("i_rdata_seq", rv[j], 32'hA0 + 32'(j));
    end
    chk("i_rvalid_count", 32'(nrv), 32'd4);
    chk("i_done_with_last_rvalid", 32'(last_rv_done), 32'h1);
    cyc();
    chk("idle_after_done_owner", 32'(owner_o), 32'h0);

    // dcache write-back at 0x2000, ack every 2nd cycle
    ack_mode = 1; ack_tgl = 0; wd_base = 32'hD0;
    d_addr_i = 32'h2000; d_we_i = 1; d_req_i = 1;
    run_burst(1, 40, ok);
    for (int j = 0; j < 4; j++) begin
      chk("wb_addr_seq", acc_addr[j], 32'h2000 + 32'(4 * j));
      chk("wb_wdata_seq", acc_wd[j], 32'hD0 + 32'(j));
      chk("wb_we", 32'(acc_we[j]), 32'h1);
    end
    chk("wb_no_rvalid", 32'(nrv), 32'h0);
    cyc(); cyc();
    chk("wb_single_done", 32'(d_done_o), 32'h0);

    // Ties twice: both request, dcache re-requests in the idle cycle
    ack_mode = 0; dir_rd = 0;
    i_addr_i = 32'h500; d_addr_i = 32'h640; d_we_i = 0;
    i_req_i = 1; d_req_i = 1;
    cyc();
    chk("tie1_owner", 32'(owner_o), 32'h2);
    run_burst(1, 30, ok);
    cyc();
    d_req_i = 1; d_addr_i = 32'h780;
    cyc();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("tie2_owner", 32'(owner_o), 32'h1);
    run_burst(0, 30, ok);
    run_burst(1, 30, ok);
`else
    chk("tie2_owner", 32'(owner_o), 32'h2);
    run_burst(1, 30, ok);
    run_burst(0, 30, ok);
`endif
    cyc();

    // Reset after the 2nd ack of an icache burst
    i_addr_i = 32'h300; i_req_i = 1;
    cyc(); cyc(); cyc();
    chk("pre_rst_addr", mem_addr_o, 32'h308);
    rst_i = 0; i_req_i = 0;
    cyc();
    chk("mid_rst_owner", 32'(owner_o), 32'h0);
    chk("mid_rst_mem_req", 32'(mem_req_o), 32'h0);
    chk("mid_rst_no_done", 32'(i_done_o), 32'h0);
    rst_i = 1;
    d_addr_i = 32'h440; d_we_i = 0; d_req_i = 1;
    run_burst(1, 30, ok);
    chk("post_rst_d_rvalids", 32'(nrv), 32'd4);
    cyc();

    // icache request raised during a dcache burst
    d_addr_i = 32'h900; d_we_i = 0; d_req_i = 1;
    cyc(); cyc();
    i_addr_i = 32'hA04; i_req_i = 1;
    run_burst(1, 30, ok);
    chk("mid_i_no_strobes", 32'(other), 32'h0);
    run_burst(0, 30, ok);
    chk("mid_i_served", 32'(nrv), 32'd4);
    cyc();

    // Randomized traffic
    ack_mode = 2; dir_rd = 0; wd_base = $urandom;
    for (int c = 0; c < 4000; c++) begin
      cyc();
      if ($urandom_range(0, 299) == 0) begin
        rst_i = 0; i_req_i = 0; d_req_i = 0;
      end else begin
        rst_i = 1;
        if (i_req_i && i_done_o) begin i_req_i = 0; n_bursts++; end
        else if (!i_req_i && $urandom_range(0, 3) == 0) begin
          i_addr_i = $urandom; i_req_i = 1;
        end
        if (d_req_i && d_done_o) begin d_req_i = 0; n_bursts++; end
        else if (!d_req_i && $urandom_range(0, 3) == 0) begin
          d_addr_i = $urandom; d_we_i = $urandom_range(0, 1); d_req_i = 1;
        end
      end
    end
    rst_i = 1; i_req_i = 0; d_req_i = 0;
    cyc(); cyc();
    chk("random_progress", 32'(n_bursts > 50), 32'h1);

    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
